// File: rtl/mod_restoring16_16_if.sv
// rtl/mod_restoring16_16_if.sv - operand/result handshake bundle for the 16-bit modulus engine
interface mod_restoring16_16_if;
  logic [15:0] dd;
  logic [15:0] dv;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] rm;
  logic [15:0] quo;
  logic        dz;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output dd, dv, in_valid, out_ready,
    input  in_ready, rm, quo, dz, out_valid
  );

  modport slave (
    input  dd, dv, in_valid, out_ready,
    output in_ready, rm, quo, dz, out_valid
  );
endinterface

// File: rtl/mod_restoring16_16.sv
// rtl/mod_restoring16_16.sv - multi-cycle 16/16 unsigned restoring divider (remainder and quotient)
module mod_restoring16_16 (
  input  logic                   clk,
  input  logic                   reset,
  mod_restoring16_16_if.slave    bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [15:0] q;
  logic [15:0] d;
  logic [15:0] rem;
  logic [3:0]  count;
  logic        dz_flag;
  logic [16:0] r;
  logic [15:0] rem_sub;
  logic        sub_ok;

  // Compare must see the shifted-out bit, so it is 17 bits; the low 16 bits of r-d equal r[15:0]-d.
  always_comb begin
    r       = {rem, q[15]};
    sub_ok  = (r >= {1'b0, d});
    rem_sub = r[15:0] - d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      q       <= 16'd0;
      d       <= 16'd0;
      rem     <= 16'd0;
      count   <= 4'd0;
      dz_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (bus.dv == 16'd0) begin
              rem     <= bus.dd;
              q       <= 16'd0;
              dz_flag <= 1'b1;
              state   <= DONE;
            end else if (bus.dd < bus.dv) begin
              rem     <= bus.dd;
              q       <= 16'd0;
              dz_flag <= 1'b0;
              state   <= DONE;
            end else begin
              q       <= bus.dd;
              d       <= bus.dv;
              rem     <= 16'd0;
              count   <= 4'd0;
              dz_flag <= 1'b0;
              state   <= CALC;
            end
          end
        end
        CALC: begin
          if (sub_ok) begin
            rem <= rem_sub;
            q   <= {q[14:0], 1'b1};
          end else begin
            rem <= r[15:0];
            q   <= {q[14:0], 1'b0};
          end
          count <= count + 4'd1;
          if (count == 4'd15) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Result ports are gated by state so nothing partial ever leaks out.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.rm        = (state == DONE) ? rem : 16'd0;
  assign bus.quo       = (state == DONE) ? q : 16'd0;
  assign bus.dz        = (state == DONE) ? dz_flag : 1'b0;
endmodule
